// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: registered ALU with LEGv8 ALU-control decode.
// Single-cycle ops are captured on the accept edge. MUL runs an iterative
// radix-2 shift-add multiplier for WIDTH cycles. Results go out over a
// valid/ready handshake.
//
// state | meaning
// IDLE  | accepting requests, holding or draining the output registers
// MUL   | shift-add multiply in progress, in_ready low
module alu_ctrl_pipe #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUOp,
  input  logic [10:0]      OpcodeField,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       ALUoperation,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_ORR   = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_LSL   = 4'b1000;
  localparam logic [3:0] OP_LSR   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_ILL   = 4'b1111;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;

  logic [3:0]       op_dec;
  logic [WIDTH-1:0] bop;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] ex_res;
  logic             ex_carry;
  logic             ex_ovf;
  logic             accept;

  // A new request can enter only from IDLE and only if the output slot frees up.
  assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign acc_next = acc + (mul_b[0] ? mul_a : '0);

  // Decode main-control class and opcode field into the 4-bit ALU operation.
  always_comb begin
    op_dec = OP_ILL;
    unique case (ALUOp)
      2'b00: op_dec = OP_ADD;
      2'b01: op_dec = OP_PASSB;
      2'b11: op_dec = OP_ILL;
      2'b10: begin
        unique case (OpcodeField)
          11'b10001010000: op_dec = OP_AND;
          11'b10101010000: op_dec = OP_ORR;
          11'b10001011000: op_dec = OP_ADD;
          11'b11001011000: op_dec = OP_SUB;
          11'b11111000010: op_dec = OP_PASSB;
          11'b11101010000: op_dec = OP_NOR;
          11'b11010011011: op_dec = OP_LSL;
          11'b11010011010: op_dec = OP_LSR;
          11'b10011011000: op_dec = OP_MUL;
          default:         op_dec = OP_ILL;
        endcase
      end
      default: op_dec = OP_ILL;
    endcase
  end

  // Single-cycle execute; ADD and SUB share one adder (SUB = A + ~B + 1).
  always_comb begin
    bop      = (op_dec == OP_SUB) ? ~B : B;
    sum      = {1'b0, A} + {1'b0, bop} + (WIDTH+1)'(op_dec == OP_SUB);
    ex_res   = '0;
    ex_carry = 1'b0;
    ex_ovf   = 1'b0;
    case (op_dec)
      OP_AND:   ex_res = A & B;
      OP_ORR:   ex_res = A | B;
      OP_NOR:   ex_res = ~(A | B);
      OP_PASSB: ex_res = B;
      OP_LSL:   ex_res = B << shamt;
      OP_LSR:   ex_res = B >> shamt;
      OP_ADD, OP_SUB: begin
        ex_res   = sum[WIDTH-1:0];
        ex_carry = sum[WIDTH];
        ex_ovf   = (A[WIDTH-1] == bop[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      default:  ex_res = '0;
    endcase
  end

  // Control FSM with output registers; results only change when written.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      mul_a        <= '0;
      mul_b        <= '0;
      acc          <= '0;
      out_valid    <= 1'b0;
      result       <= '0;
      ALUoperation <= 4'b0000;
      zero         <= 1'b0;
      negative     <= 1'b0;
      carry        <= 1'b0;
      overflow     <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op_dec == OP_MUL) begin
              mul_a     <= A;
              mul_b     <= B;
              acc       <= '0;
              cnt       <= '0;
              out_valid <= 1'b0;
              state     <= S_MUL;
            end else begin
              result       <= ex_res;
              ALUoperation <= op_dec;
              zero         <= (ex_res == '0);
              negative     <= ex_res[WIDTH-1];
              carry        <= ex_carry;
              overflow     <= ex_ovf;
              illegal      <= (op_dec == OP_ILL);
              out_valid    <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        S_MUL: begin
          acc   <= acc_next;
          mul_a <= mul_a << 1;
          mul_b <= mul_b >> 1;
          cnt   <= cnt + SHW'(1);
          if (cnt == SHW'(WIDTH-1)) begin
            result       <= acc_next;
            ALUoperation <= OP_MUL;
            zero         <= (acc_next == '0);
            negative     <= acc_next[WIDTH-1];
            carry        <= 1'b0;
            overflow     <= 1'b0;
            illegal      <= 1'b0;
            out_valid    <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
